// File: rtl/jtag_stream_arbiter.sv
// jtag_stream_arbiter: shares one 8-bit JTAG byte-stream bridge between N_CH
// client channels. Tx round-robins client bytes onto the bridge with an
// ESC,<ch> header on every channel switch and ESC doubling of payload.
// Rx parses the same framing and routes payload bytes to the addressed client.
// Optional: define JTAG_ARB_ERRCNT_EN to add rx_err_cnt / err_clr.
//
// Tx state  | meaning
// T_IDLE    | arbitrate, pick grant starting at rr_ptr
// T_HDR_ESC | emit ESC of channel header
// T_HDR_CH  | emit channel number, latch last_ch
// T_DATA    | emit payload byte (acks unless it is ESC)
// T_DATA_E2 | emit second ESC of an escaped payload byte, ack
// Rx state  | meaning
// R_DATA    | plain payload byte expected
// R_ESC     | byte after ESC: ESC literal or channel select
module jtag_stream_arbiter #(
    parameter int         N_CH      = 4,
    parameter int         MAX_BURST = 16,
    parameter logic [7:0] ESC       = 8'h1B
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CH-1:0]     ch_req,
    input  logic [8*N_CH-1:0]   ch_data,
    output logic [N_CH-1:0]     ch_ack,
    output logic [N_CH-1:0]     rx_valid,
    output logic [7:0]          rx_data,
    output logic                br_write,
    output logic [7:0]          br_writedata,
    input  logic                br_ready,
    input  logic                br_rxvalid,
    input  logic [7:0]          br_rxdata
`ifdef JTAG_ARB_ERRCNT_EN
    ,
    output logic [7:0]          rx_err_cnt,
    input  logic                err_clr
`endif
);

    localparam int CW = $clog2(N_CH);

    typedef enum logic [2:0] {T_IDLE, T_HDR_ESC, T_HDR_CH, T_DATA, T_DATA_E2} tx_state_t;
    typedef enum logic {R_DATA, R_ESC} rx_state_t;

    tx_state_t         tx_state;
    rx_state_t         rx_state;
    logic [CW-1:0]     grant, last_ch, rr_ptr, pick, rr_next, rx_ch;
    logic              last_vld, pick_found;
    logic [7:0]        burst_cnt, cur_byte, emit_byte;
    logic              grant_req, emit, ack_now;

    assign cur_byte  = ch_data[8*grant +: 8];
    assign grant_req = ch_req[grant];
    assign rr_next   = (grant == CW'(N_CH-1)) ? '0 : grant + 1'b1;

    // Round-robin search: first requester at or after rr_ptr
    always_comb begin
        int idx;
        pick_found = 1'b0;
        pick       = rr_ptr;
        for (int i = 0; i < N_CH; i++) begin
            idx = (int'(rr_ptr) + i) % N_CH;
            if (!pick_found && ch_req[idx]) begin
                pick_found = 1'b1;
                pick       = CW'(idx);
            end
        end
    end

    // Byte presented to the bridge in each emitting state; write gated by br_ready
    always_comb begin
        emit      = 1'b0;
        emit_byte = ESC;
        ack_now   = 1'b0;
        case (tx_state)
            T_HDR_ESC: emit = 1'b1;
            T_HDR_CH: begin
                emit      = 1'b1;
                emit_byte = {{(8-CW){1'b0}}, grant};
            end
            T_DATA: begin
                emit      = grant_req;
                emit_byte = cur_byte;
                ack_now   = grant_req && (cur_byte != ESC);
            end
            T_DATA_E2: begin
                emit    = 1'b1;
                ack_now = 1'b1;
            end
            default: ;
        endcase
        br_write     = emit & br_ready;
        br_writedata = emit_byte;
        ch_ack       = (ack_now && br_ready) ? (N_CH'(1) << grant) : '0;
    end

    // Tx sequencing: arbitration, header insertion, escaping, burst limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= T_IDLE;
            grant     <= '0;
            last_ch   <= '0;
            last_vld  <= 1'b0;
            burst_cnt <= '0;
            rr_ptr    <= '0;
        end else begin
            case (tx_state)
                T_IDLE: begin
                    if (pick_found) begin
                        grant     <= pick;
                        burst_cnt <= '0;
                        tx_state  <= (last_vld && pick == last_ch) ? T_DATA : T_HDR_ESC;
                    end
                end
                T_HDR_ESC: begin
                    if (br_ready) tx_state <= T_HDR_CH;
                end
                T_HDR_CH: begin
                    if (br_ready) begin
                        last_ch  <= grant;
                        last_vld <= 1'b1;
                        if (grant_req) begin
                            tx_state <= T_DATA;
                        end else begin
                            tx_state <= T_IDLE;
                            rr_ptr   <= rr_next;
                        end
                    end
                end
                T_DATA, T_DATA_E2: begin
                    if (tx_state == T_DATA && !grant_req) begin
                        tx_state <= T_IDLE;
                        rr_ptr   <= rr_next;
                    end else if (br_ready) begin
                        if (tx_state == T_DATA && cur_byte == ESC) begin
                            tx_state <= T_DATA_E2;
                        end else begin
                            burst_cnt <= burst_cnt + 8'd1;
                            if (burst_cnt + 8'd1 == 8'(MAX_BURST)) begin
                                tx_state <= T_IDLE;
                                rr_ptr   <= rr_next;
                            end else begin
                                tx_state <= T_DATA;
                            end
                        end
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    // Rx parser: unescape and route payload with one cycle of latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= R_DATA;
            rx_ch    <= '0;
            rx_valid <= '0;
            rx_data  <= '0;
        end else begin
            rx_valid <= '0;
            if (br_rxvalid) begin
                if (rx_state == R_DATA) begin
                    if (br_rxdata == ESC) begin
                        rx_state <= R_ESC;
                    end else begin
                        rx_valid <= N_CH'(1) << rx_ch;
                        rx_data  <= br_rxdata;
                    end
                end else begin
                    rx_state <= R_DATA;
                    if (br_rxdata == ESC) begin
                        rx_valid <= N_CH'(1) << rx_ch;
                        rx_data  <= br_rxdata;
                    end else if (int'(br_rxdata) < N_CH) begin
                        rx_ch <= br_rxdata[CW-1:0];
                    end
                end
            end
        end
    end

`ifdef JTAG_ARB_ERRCNT_EN
    logic rx_err;
    assign rx_err = br_rxvalid && (rx_state == R_ESC) && (br_rxdata != ESC)
                    && (int'(br_rxdata) >= N_CH);

    // Saturating framing-error counter; clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_err_cnt <= '0;
        end else if (err_clr) begin
            rx_err_cnt <= '0;
        end else if (rx_err && rx_err_cnt != 8'hFF) begin
            rx_err_cnt <= rx_err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jtag_stream_arbiter.sv
// Scoreboard bench for jtag_stream_arbiter (N_CH=4, MAX_BURST=2).
module tb_jtag_stream_arbiter;

    localparam int N = 4;

    logic            clk = 0;
    logic            rst;
    logic [N-1:0]    ch_req;
    logic [8*N-1:0]  ch_data;
    logic [N-1:0]    ch_ack;
    logic [N-1:0]    rx_valid;
    logic [7:0]      rx_data;
    logic            br_write;
    logic [7:0]      br_writedata;
    logic            br_ready;
    logic            br_rxvalid;
    logic [7:0]      br_rxdata;
`ifdef JTAG_ARB_ERRCNT_EN
    logic [7:0]      rx_err_cnt;
    logic            err_clr;
`endif

    jtag_stream_arbiter #(.N_CH(N), .MAX_BURST(2), .ESC(8'h1B)) dut (
        .clk(clk), .rst(rst), .ch_req(ch_req), .ch_data(ch_data), .ch_ack(ch_ack),
        .rx_valid(rx_valid), .rx_data(rx_data), .br_write(br_write),
        .br_writedata(br_writedata), .br_ready(br_ready), .br_rxvalid(br_rxvalid),
        .br_rxdata(br_rxdata)
`ifdef JTAG_ARB_ERRCNT_EN
        , .rx_err_cnt(rx_err_cnt), .err_clr(err_clr)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  chq [N][$];
    logic [11:0] exp_tx [$];   // {ack vector, byte}
    logic [11:0] exp_rx [$];   // {rx_valid vector, byte}
    logic [N-1:0] ack_seen = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic etx(input logic [7:0] b, input int ack_ch);
        logic [3:0] a;
        a = (ack_ch < 0) ? 4'b0 : (4'b1 << ack_ch);
        exp_tx.push_back({a, b});
    endtask

    task automatic erx(input int ch, input logic [7:0] b);
        logic [3:0] v;
        v = 4'b1 << ch;
        exp_rx.push_back({v, b});
    endtask

    task automatic wait_tx_empty(input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            @(posedge clk);
            if (exp_tx.size() == 0) break;
        end
        if (i == limit) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_timeout: %0d bytes still expected", exp_tx.size());
            exp_tx.delete();
        end
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(posedge clk); #1;
        br_rxvalid = 1'b1;
        br_rxdata  = b;
        @(posedge clk); #1;
        br_rxvalid = 1'b0;
    endtask

    // Client model: pop on each observed ack, present queue head
    initial begin
        ch_req  = '0;
        ch_data = '0;
        forever begin
            @(posedge clk); #1;
            for (int n = 0; n < N; n++) begin
                if (ack_seen[n] && chq[n].size() != 0) void'(chq[n].pop_front());
                ch_req[n]        = (chq[n].size() != 0);
                ch_data[8*n +: 8] = (chq[n].size() != 0) ? chq[n][0] : 8'h00;
            end
        end
    end

    // Monitor: compare bridge writes and rx deliveries against the scoreboard
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            ack_seen = ch_ack;
            if (!br_ready) check("no_write_when_not_ready", {31'b0, br_write}, 32'd0);
            if (br_write) begin
                if (exp_tx.size() == 0) begin
                    check("tx_unexpected_byte", {24'b0, br_writedata}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_tx.pop_front();
                    check("tx_byte", {24'b0, br_writedata}, {24'b0, e[7:0]});
                    check("tx_ack", {28'b0, ch_ack}, {28'b0, e[11:8]});
                end
            end else if (ch_ack != '0) begin
                check("ack_without_write", {28'b0, ch_ack}, 32'd0);
            end
            if (rx_valid != '0) begin
                if (exp_rx.size() == 0) begin
                    check("rx_unexpected", {28'b0, rx_valid}, 32'd0);
                end else begin
                    e = exp_rx.pop_front();
                    check("rx_valid", {28'b0, rx_valid}, {28'b0, e[11:8]});
                    check("rx_data", {24'b0, rx_data}, {24'b0, e[7:0]});
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        br_ready   = 1'b1;
        br_rxvalid = 1'b0;
        br_rxdata  = 8'h00;
`ifdef JTAG_ARB_ERRCNT_EN
        err_clr    = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_ch_ack", {28'b0, ch_ack}, 32'd0);
        check("reset_rx_valid", {28'b0, rx_valid}, 32'd0);
        check("reset_rx_data", {24'b0, rx_data}, 32'd0);
        check("reset_br_write", {31'b0, br_write}, 32'd0);
`ifdef JTAG_ARB_ERRCNT_EN
        check("reset_err_cnt", {24'b0, rx_err_cnt}, 32'd0);
`endif
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single channel, first byte after reset carries a header
        etx(8'h1B, -1); etx(8'h02, -1); etx(8'h41, 2); etx(8'h42, 2);
        chq[2].push_back(8'h41); chq[2].push_back(8'h42);
        wait_tx_empty(50);
        repeat (4) @(posedge clk);

        // Two channels competing, burst limit 2, header on every switch
        etx(8'h1B, -1); etx(8'h00, -1); etx(8'h10, 0); etx(8'h11, 0);
        etx(8'h1B, -1); etx(8'h01, -1); etx(8'h20, 1); etx(8'h21, 1);
        etx(8'h1B, -1); etx(8'h00, -1); etx(8'h12, 0); etx(8'h13, 0);
        etx(8'h1B, -1); etx(8'h01, -1); etx(8'h22, 1); etx(8'h23, 1);
        for (int i = 0; i < 4; i++) begin
            chq[0].push_back(8'h10 + 8'(i));
            chq[1].push_back(8'h20 + 8'(i));
        end
        wait_tx_empty(100);
        repeat (4) @(posedge clk);

        // Escaped payload byte with bridge backpressure
        etx(8'h1B, -1); etx(8'h03, -1); etx(8'h1B, -1); etx(8'h1B, 3);
        chq[3].push_back(8'h1B);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            br_ready = ~br_ready;
        end
        br_ready = 1'b1;
        wait_tx_empty(50);
        repeat (4) @(posedge clk);

        // Rx framing: channel select, escaped ESC, channel switch
        erx(1, 8'h55); erx(1, 8'h1B); erx(0, 8'h66);
        rx_byte(8'h1B); rx_byte(8'h01); rx_byte(8'h55);
        rx_byte(8'h1B); rx_byte(8'h1B);
        rx_byte(8'h1B); rx_byte(8'h00); rx_byte(8'h66);
        // Out-of-range channel select is dropped
        erx(0, 8'h77);
        rx_byte(8'h1B); rx_byte(8'h07); rx_byte(8'h77);
        repeat (3) @(posedge clk);
        check("rx_queue_drained", exp_rx.size(), 32'd0);
`ifdef JTAG_ARB_ERRCNT_EN
        check("err_cnt_one", {24'b0, rx_err_cnt}, 32'd1);
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        check("err_cnt_cleared", {24'b0, rx_err_cnt}, 32'd0);
`endif

        // Reset mid-burst: header is re-emitted before the remaining byte
        etx(8'h1B, -1); etx(8'h01, -1); etx(8'h30, 1);
        chq[1].push_back(8'h30); chq[1].push_back(8'h31);
        wait_tx_empty(50);
        #1 rst = 1'b1;
        etx(8'h1B, -1); etx(8'h01, -1); etx(8'h31, 1);
        @(posedge clk); #1;
        check("midrst_br_write", {31'b0, br_write}, 32'd0);
        check("midrst_ch_ack", {28'b0, ch_ack}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_tx_empty(50);
        repeat (4) @(posedge clk);

        check("tx_queue_drained", exp_tx.size(), 32'd0);
        check("rx_queue_final", exp_rx.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
